// File: rtl/rx_serial_pkg.sv
// Shared definitions for the 7O1 serial receiver: FSM state codes (also the db_estado encoding),
// character width and the default baud divisor.
package rx_serial_pkg;

  localparam int unsigned DataWidth         = 7;
  localparam int unsigned ClksPerBitDefault = 434;  // 50 MHz / 115200 baud

  typedef enum logic [3:0] {
    StInicial     = 4'h0,
    StEsperaStart = 4'h1,
    StDados       = 4'h2,
    StParidade    = 4'h3,
    StStop        = 4'h4,
    StFinal       = 4'h5,
    StArmar       = 4'hF
  } estado_e;

endpackage

// File: rtl/gerador_tick_rx.sv
// Mod-CLKS_PER_BIT counter with synchronous clear; flags the half-period and full-period counts.
module gerador_tick_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_half_o,
  output logic tick_full_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear_i || (cnt_q == FullLast)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_half_o = (cnt_q == HalfLast);
  assign tick_full_o = (cnt_q == FullLast);

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 asynchronous serial receiver (start, 7 data LSB-first, odd parity, stop), mid-bit sampled.
// Optional consumer handshake (recebe_dado / tem_dado) enabled by RX_SERIAL_HANDSHAKE_EN.
module rx_serial_7o1
  import rx_serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dado_serial,
`ifdef RX_SERIAL_HANDSHAKE_EN
  input  logic                 recebe_dado,
  output logic                 tem_dado,
`endif
  output logic [DataWidth-1:0] dados_ascii,
  output logic                 pronto,
  output logic                 erro_paridade,
  output logic                 erro_frame,
  output logic                 db_tick,
  output logic                 db_dado_serial,
  output logic [3:0]           db_estado
);

  estado_e state_d, state_q;

  logic                 sync1_q, s_q, s_prev_q;
  logic                 s;
  logic                 tick_clear, tick_half, tick_full;
  logic [DataWidth-1:0] shift_d, shift_q;
  logic [2:0]           bit_cnt_d, bit_cnt_q;
  logic                 par_d, par_q;
  logic [DataWidth-1:0] dados_d, dados_q;
  logic                 erro_par_d, erro_par_q;
  logic                 erro_frame_d, erro_frame_q;

  assign s = s_q;

  gerador_tick_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk_i      (clock),
    .rst_ni     (reset),
    .clear_i    (tick_clear),
    .tick_half_o(tick_half),
    .tick_full_o(tick_full)
  );

  always_comb begin
    state_d      = state_q;
    tick_clear   = 1'b0;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    dados_d      = dados_q;
    erro_par_d   = erro_par_q;
    erro_frame_d = erro_frame_q;
    pronto       = 1'b0;
    db_tick      = 1'b0;

    unique case (state_q)
      StArmar: begin
        // Three high samples in a row; s_prev resets low so the synchronizer's reset value
        // alone cannot arm us on a line that is held low.
        if (sync1_q && s && s_prev_q) begin
          state_d = StInicial;
        end
      end
      StInicial: begin
        if (!s && s_prev_q) begin
          state_d    = StEsperaStart;
          tick_clear = 1'b1;
        end
      end
      StEsperaStart: begin
        if (tick_half) begin
          db_tick = 1'b1;
          if (!s) begin
            state_d    = StDados;
            tick_clear = 1'b1;  // re-phase so full ticks land on bit centres
            bit_cnt_d  = '0;
          end else begin
            state_d = StInicial;
          end
        end
      end
      StDados: begin
        if (tick_full) begin
          db_tick   = 1'b1;
          shift_d   = {s, shift_q[DataWidth-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DataWidth - 1)) begin
            state_d = StParidade;
          end
        end
      end
      StParidade: begin
        if (tick_full) begin
          db_tick = 1'b1;
          par_d   = s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (tick_full) begin
          db_tick      = 1'b1;
          dados_d      = shift_q;
          erro_par_d   = ~((^shift_q) ^ par_q);
          erro_frame_d = ~s;
          state_d      = StFinal;
        end
      end
      StFinal: begin
        pronto  = 1'b1;
        state_d = StInicial;
      end
      default: state_d = StArmar;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b1;
      s_q          <= 1'b1;
      s_prev_q     <= 1'b0;
      state_q      <= StArmar;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      dados_q      <= '0;
      erro_par_q   <= 1'b0;
      erro_frame_q <= 1'b0;
    end else begin
      sync1_q      <= dado_serial;
      s_q          <= sync1_q;
      s_prev_q     <= s_q;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      dados_q      <= dados_d;
      erro_par_q   <= erro_par_d;
      erro_frame_q <= erro_frame_d;
    end
  end

`ifdef RX_SERIAL_HANDSHAKE_EN
  logic tem_dado_d, tem_dado_q;

  always_comb begin
    tem_dado_d = tem_dado_q;
    if (state_q == StFinal) begin
      tem_dado_d = 1'b1;
    end else if (recebe_dado) begin
      tem_dado_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tem_dado_q <= 1'b0;
    end else begin
      tem_dado_q <= tem_dado_d;
    end
  end

  assign tem_dado = tem_dado_q;
`endif

  assign dados_ascii    = dados_q;
  assign erro_paridade  = erro_par_q;
  assign erro_frame     = erro_frame_q;
  assign db_dado_serial = s_q;
  assign db_estado      = state_q;

endmodule
